scm_wr_rmw_arbiter: RTL and testbench

- Shares the single 64-bit write port of a 1W/multi-read SCM between N_REQ 32-bit write requesters, using round-robin arbitration.
- The SCM has no byte or half enables, so each 32-bit write runs as a read-modify-write.
- The block reads the partner 32-bit half through one dedicated SCM read port, merges it with the new half, and issues one 64-bit row write.
- It sits between the requesters and the SCM read/write port pins.

---
 rtl/scm_wr_rmw_arbiter.sv | 138 +++++++++++++
 tb/tb_scm_wr_rmw_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scm_wr_rmw_arbiter.sv
// scm_wr_rmw_arbiter: round-robin share of one 64-bit SCM write port among
// N_REQ 32-bit writers; each write is a read-modify-write of its 64-bit row.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_i/addr_i/wdata_i  per-requester write request, word address, data
//   gnt_o                 one-hot grant (IDLE only, combinational)
//   done_o                one-cycle pulse after the row write commits
//   busy_o                high while a transaction is in flight
//   rf_Read*              SCM read port (partner half fetch)
//   rf_Write*             SCM write port (merged 64-bit row)
module scm_wr_rmw_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WADDR_WIDTH = 5,
  parameter int RADDR_WIDTH = WADDR_WIDTH + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ-1:0][RADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ-1:0][31:0]              wdata_i,
  output logic [N_REQ-1:0]                    gnt_o,
  output logic [N_REQ-1:0]                    done_o,
  output logic                                busy_o,
  output logic                                rf_ReadEnable_o,
  output logic [RADDR_WIDTH-1:0]              rf_ReadAddr_o,
  input  logic [31:0]                         rf_ReadData_i,
  output logic                                rf_WriteEnable_o,
  output logic [WADDR_WIDTH-1:0]              rf_WriteAddr_o,
  output logic [63:0]                         rf_WriteData_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                 state;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          idx_q;
  logic [WADDR_WIDTH-1:0] row_q;
  logic                   half_q;
  logic [31:0]            wdata_q;
  logic [63:0]            wd_hold;

  logic                   win_valid;
  logic [IW-1:0]          win_idx;
  logic [IW-1:0]          ptr_nxt;
  logic [63:0]            merged;
  int                     j;

  // Search upward from the pointer with wrap; first requester found wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!win_valid && req_i[j]) begin
        win_valid = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    if (win_idx == IW'(N_REQ - 1)) ptr_nxt = '0;
    else                           ptr_nxt = win_idx + 1'b1;
  end

  always_comb begin
    gnt_o = '0;
    if (state == IDLE && win_valid) gnt_o[win_idx] = 1'b1;
  end

  // Partner half arrives from the SCM during WRITE, so the merge is
  // combinational there; otherwise the last written row is held.
  always_comb begin
    if (half_q) merged = {wdata_q, rf_ReadData_i};
    else        merged = {rf_ReadData_i, wdata_q};
  end

  assign rf_WriteData_o = (state == WRITE) ? merged : wd_hold;
  assign busy_o         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= '0;
      idx_q            <= '0;
      row_q            <= '0;
      half_q           <= 1'b0;
      wdata_q          <= '0;
      wd_hold          <= '0;
      done_o           <= '0;
      rf_ReadEnable_o  <= 1'b0;
      rf_ReadAddr_o    <= '0;
      rf_WriteEnable_o <= 1'b0;
      rf_WriteAddr_o   <= '0;
    end else begin
      done_o <= '0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            idx_q           <= win_idx;
            row_q           <= addr_i[win_idx][RADDR_WIDTH-1:1];
            half_q          <= addr_i[win_idx][0];
            wdata_q         <= wdata_i[win_idx];
            ptr             <= ptr_nxt;
            rf_ReadEnable_o <= 1'b1;
            rf_ReadAddr_o   <= {addr_i[win_idx][RADDR_WIDTH-1:1],
                                ~addr_i[win_idx][0]};
            state           <= READ;
          end
        end
        READ: begin
          rf_ReadEnable_o  <= 1'b0;
          rf_WriteEnable_o <= 1'b1;
          rf_WriteAddr_o   <= row_q;
          state            <= WRITE;
        end
        WRITE: begin
          rf_WriteEnable_o <= 1'b0;
          wd_hold          <= merged;
          done_o           <= N_REQ'(1) << idx_q;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scm_wr_rmw_arbiter.sv
// tb_scm_wr_rmw_arbiter: directed bench with an SCM model, a per-cycle
// transaction-level reference model and literal spot checks.
module tb_scm_wr_rmw_arbiter;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [3:0][5:0]   addr;
  logic [3:0][31:0]  wdata;
  logic [3:0]        gnt;
  logic [3:0]        done;
  logic              busy;
  logic              ren;
  logic [5:0]        raddr;
  logic [31:0]       rdata;
  logic              wen;
  logic [4:0]        waddr;
  logic [63:0]       wdat;

  int checks = 0;
  int errors = 0;

  scm_wr_rmw_arbiter #(
    .N_REQ(4), .WADDR_WIDTH(5), .RADDR_WIDTH(6)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_i            (req),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .gnt_o            (gnt),
    .done_o           (done),
    .busy_o           (busy),
    .rf_ReadEnable_o  (ren),
    .rf_ReadAddr_o    (raddr),
    .rf_ReadData_i    (rdata),
    .rf_WriteEnable_o (wen),
    .rf_WriteAddr_o   (waddr),
    .rf_WriteData_o   (wdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] init_row(input int r);
    case (r)
      3:       return 64'h11112222_33334444;
      5:       return 64'h12345678_9ABCDEF0;
      8:       return 64'hFFFF0000_FFFF0000;
      default: return 64'(r) * 64'h01010101_01010101;
    endcase
  endfunction

  // SCM: 1-cycle read latency, row written on the clock edge.
  logic [63:0] smem [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) smem[r] <= init_row(r);
    end else begin
      if (wen) smem[waddr] <= wdat;
      if (ren) rdata <= raddr[0] ? smem[raddr[5:1]][63:32]
                                 : smem[raddr[5:1]][31:0];
    end
  end

  // Reference model: a transaction is "cycles since grant" (0..2);
  // its memory image is updated when the modelled write lands.
  logic [63:0] ref_mem [32];
  int          ph;
  int          ptr_m;
  int          k_m;
  logic [5:0]  a_m;
  logic [31:0] d_m;
  logic [3:0]  done_pend;
  logic [5:0]  ra_h;
  logic [4:0]  wa_h;
  logic [63:0] wd_h;
  logic [3:0]  eg;
  logic [63:0] wd_e;
  int          glog[$];
  int          wtotal = 0;
  int          dtotal = 0;

  always @(negedge clk) begin
    if (wen) wtotal++;
    if (done != 0) dtotal++;
    for (int i = 0; i < 4; i++) if (gnt[i]) glog.push_back(i);
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ren", ren, 0);
      chk("rst_wen", wen, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdat, 0);
      for (int r = 0; r < 32; r++) ref_mem[r] = init_row(r);
      ph = 0; ptr_m = 0; k_m = 0; a_m = 0; d_m = 0;
      done_pend = 0; ra_h = 0; wa_h = 0; wd_h = 0;
    end else begin
      eg = 0;
      k_m = k_m;
      if (ph == 0) begin
        for (int i = 0; i < 4; i++)
          if (eg == 0 && req[(ptr_m + i) % 4]) begin
            eg[(ptr_m + i) % 4] = 1'b1;
            k_m = (ptr_m + i) % 4;
          end
      end
      if (ph == 1) ra_h = {a_m[5:1], ~a_m[0]};
      if (ph == 2) begin
        wa_h = a_m[5:1];
        wd_e = ref_mem[a_m[5:1]];
        if (a_m[0]) wd_h = {d_m, wd_e[31:0]};
        else        wd_h = {wd_e[63:32], d_m};
      end
      chk("gnt", gnt, eg);
      chk("busy", busy, ph != 0);
      chk("ren", ren, ph == 1);
      chk("wen", wen, ph == 2);
      chk("raddr", raddr, ra_h);
      chk("waddr", waddr, wa_h);
      chk("wdata", wdat, wd_h);
      chk("done", done, done_pend);
      done_pend = 0;
      if (ph == 0 && eg != 0) begin
        a_m   = addr[k_m];
        d_m   = wdata[k_m];
        ptr_m = (k_m + 1) % 4;
        ph    = 1;
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2) begin
        ref_mem[a_m[5:1]] = wd_h;
        done_pend = 4'b0001 << k_m;
        ph = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int gb;
  int w0;
  int d0;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    wdata = '0;
    cyc(3);
    rst_n = 1'b1;

    // single write to row 3 hi
    cyc(1);
    req = 4'b0001; addr[0] = 6'h07; wdata[0] = 32'hDEADBEEF;
    @(negedge clk); chk("t1_gnt", gnt, 4'b0001);
    cyc(1); req = 4'b0000;
    @(negedge clk);
    chk("t1_ren", ren, 1);
    chk("t1_raddr", raddr, 6'h06);
    @(negedge clk);
    chk("t1_wen", wen, 1);
    chk("t1_waddr", waddr, 5'd3);
    chk("t1_wdata", wdat, 64'hDEADBEEF_33334444);
    @(negedge clk); chk("t1_done", done, 4'b0001);
    cyc(2);

    // round-robin with all four requesting
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = 6'(16 + 2 * i);
      wdata[i] = 32'hA0A0_0000 + 32'(i);
    end
    gb = glog.size();
    d0 = dtotal;
    req = 4'b1111;
    cyc(13); req = 4'b0000;
    cyc(4);
    chk("t2_ngrants", glog.size() - gb, 5);
    chk("t2_g0", glog[gb], 0);
    chk("t2_g1", glog[gb + 1], 1);
    chk("t2_g2", glog[gb + 2], 2);
    chk("t2_g3", glog[gb + 3], 3);
    chk("t2_g4", glog[gb + 4], 0);
    chk("t2_ndone", dtotal - d0, 5);

    // same-row pair, requesters 1 then 2
    gb = glog.size();
    addr[1] = 6'h0A; wdata[1] = 32'hAAAAAAAA;
    addr[2] = 6'h0B; wdata[2] = 32'h55555555;
    req = 4'b0110;
    cyc(1); req = 4'b0100;
    cyc(2);
    cyc(1); req = 4'b0000;
    cyc(4);
    chk("t3_g0", glog[gb], 1);
    chk("t3_g1", glog[gb + 1], 2);
    chk("t3_row5", smem[5], 64'h55555555_AAAAAAAA);

    // pointer wrap from 3 to 0
    gb = glog.size();
    addr[3] = 6'h1F; wdata[3] = 32'h33333333;
    addr[0] = 6'h00; wdata[0] = 32'h00000001;
    req = 4'b1001;
    cyc(1); req = 4'b0001;
    cyc(2);
    cyc(1); req = 4'b0000;
    cyc(4);
    chk("t4_g0", glog[gb], 3);
    chk("t4_g1", glog[gb + 1], 0);

    // reset in READ aborts the write
    addr[2] = 6'h12; wdata[2] = 32'h77777777;
    req = 4'b0100;
    @(negedge clk); chk("t5_gnt", gnt, 4'b0100);
    cyc(1); req = 4'b0000;
    w0 = wtotal; d0 = dtotal;
    #2 rst_n = 1'b0;
    cyc(3);
    chk("t5_nowrite", wtotal - w0, 0);
    chk("t5_nodone", dtotal - d0, 0);
    rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk); chk("t5_ptr0", gnt, 4'b0001);
    cyc(1); req = 4'b0000;
    cyc(4);

    // requester 2 drops req right after its grant
    addr[2] = 6'h10; wdata[2] = 32'hCAFEF00D;
    req = 4'b0100;
    @(negedge clk); chk("t6_gnt", gnt, 4'b0100);
    cyc(1); req = 4'b0000;
    @(negedge clk); chk("t6_raddr", raddr, 6'h11);
    @(negedge clk); chk("t6_wen", wen, 1);
    @(negedge clk); chk("t6_done", done, 4'b0100);
    cyc(2);
    chk("t6_row8", smem[8], 64'hFFFF0000_CAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
